// File: rtl/alu_sequencer.sv
// ALU micro-sequencer: runs a small instruction program against an external
// ALU and register file, repeating the program loops+1 times per start.
// Handshake: start is a level sampled only in IDLE; busy stays high from the
// first FETCH until the last instruction retires, then done pulses for one
// cycle. A write-back is offered by holding wr_en high for exactly one cycle
// with wr_addr/wr_data stable; the consumer has no way to stall it.
module alu_sequencer #(
  parameter int PROG_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       prog_we,
  input  logic [2:0] prog_addr,
  input  logic [7:0] prog_data,
  input  logic       start,
  input  logic [3:0] loops,
  output logic       busy,
  output logic       done,
  output logic [2:0] pc,
  output logic [1:0] alu_sel_a,
  output logic [1:0] alu_sel_b,
  output logic [3:0] alu_op,
  input  logic [7:0] alu_result,
  output logic       wr_en,
  output logic [1:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_WB    = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] OP_HALT = 2'b11;

  state_t     state;
  logic [7:0] mem [PROG_DEPTH];
  logic [7:0] instr;
  logic [3:0] pass_cnt;
  logic [7:0] fetch_word;
  logic       mem_we;
  logic       step;
  logic       end_pass;

  assign state_dbg  = state;
  assign fetch_word = mem[pc];

  // Program memory is only writable while no run is in flight.
  assign mem_we = prog_we && (state == S_IDLE || state == S_DONE);

  // A step retires the current instruction: after write-back, or straight
  // out of EXEC for NOP/HALT (opcode bit 7 set).
  assign step = (state == S_WB) || (state == S_EXEC && instr[7]);

  // A pass ends on HALT or when moving past the last program word.
  assign end_pass = (state == S_EXEC && instr[7:6] == OP_HALT) || (pc == 3'd7);

  // Sequencer FSM, program memory and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pc        <= 3'd0;
      alu_sel_a <= 2'b00;
      alu_sel_b <= 2'b01;
      alu_op    <= 4'b0000;
      wr_en     <= 1'b0;
      wr_addr   <= 2'd0;
      wr_data   <= 8'd0;
      pass_cnt  <= 4'd0;
      instr     <= 8'hFF;
      mem       <= '{default: 8'hFF};
    end else begin
      // Single-cycle outputs fall back to their quiet values every cycle.
      done      <= 1'b0;
      wr_en     <= 1'b0;
      alu_sel_a <= 2'b00;
      alu_sel_b <= 2'b01;
      alu_op    <= 4'b0000;

      if (mem_we) begin
        mem[prog_addr] <= prog_data;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            pass_cnt <= loops;
            pc       <= 3'd0;
            busy     <= 1'b1;
            state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          // ALU controls are set up here so they are valid for all of EXEC.
          instr     <= fetch_word;
          alu_sel_a <= fetch_word[5:4];
          alu_sel_b <= fetch_word[3:2];
          alu_op    <= fetch_word[7] ? 4'b0000 : {3'b000, fetch_word[6]};
          state     <= S_EXEC;
        end
        S_EXEC: begin
          if (!instr[7]) begin
            wr_data <= alu_result;
            wr_addr <= instr[1:0];
            wr_en   <= 1'b1;
            state   <= S_WB;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          // S_WB only retires; the step logic below picks the next state.
        end
      endcase

      if (step) begin
        if (end_pass) begin
          pc <= 3'd0;
          if (pass_cnt != 4'd0) begin
            pass_cnt <= pass_cnt - 4'd1;
            state    <= S_FETCH;
          end else begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end else begin
          pc    <= pc + 3'd1;
          state <= S_FETCH;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: an environment ALU + register file, a program-level
// reference model that expands each run into an expected per-cycle trace,
// and one compare process that checks every cycle against that trace.
module tb_alu_sequencer;

  logic       clk;
  logic       rst;
  logic       prog_we;
  logic [2:0] prog_addr;
  logic [7:0] prog_data;
  logic       start;
  logic [3:0] loops;
  logic       busy;
  logic       done;
  logic [2:0] pc;
  logic [1:0] alu_sel_a;
  logic [1:0] alu_sel_b;
  logic [3:0] alu_op;
  logic [7:0] alu_result;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [2:0] state_dbg;

  alu_sequencer #(.PROG_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .loops(loops), .busy(busy),
    .done(done), .pc(pc), .alu_sel_a(alu_sel_a), .alu_sel_b(alu_sel_b),
    .alu_op(alu_op), .alu_result(alu_result), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- environment ALU / register file ----------------
  logic [7:0] rf      [4];
  logic [7:0] rf_init [4];
  logic       rf_load;

  always @(posedge clk) begin
    if (rf_load) rf <= rf_init;
    else if (wr_en) rf[wr_addr] <= wr_data;
  end

  assign alu_result = (alu_op == 4'd1) ? rf[alu_sel_a] - rf[alu_sel_b]
                                       : rf[alu_sel_a] + rf[alu_sel_b];

  // ---------------- reference model state ----------------
  typedef struct {
    logic       busy;
    logic       done;
    logic [2:0] pc;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [3:0] op;
    logic       we;
    logic [1:0] wa;
    logic [7:0] wd;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mmem [8];
  logic [7:0] mrf  [4];

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  int         cyc_ctr = 0;
  int         run_base = 0;
  int         last_done_rel = -1;
  int         done_cnt = 0;
  logic [9:0] wr_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic exp_t idle_exp();
    exp_t e;
    e.busy = 1'b0; e.done = 1'b0; e.pc = 3'd0; e.sa = 2'b00; e.sb = 2'b01;
    e.op = 4'd0; e.we = 1'b0; e.wa = 2'd0; e.wd = 8'd0;
    return e;
  endfunction

  // Expand a whole run into cycles: ADD/SUB = fetch, exec, write-back;
  // NOP = fetch, exec; HALT = fetch, exec and ends the pass; one done cycle.
  task automatic build_trace(input int lp);
    exp_t e;
    logic [7:0] w;
    logic [7:0] res;
    for (int p = 0; p <= lp; p++) begin
      for (int a = 0; a < 8; a++) begin
        w = mmem[a];
        e = idle_exp();
        e.busy = 1'b1;
        e.pc   = 3'(a);
        exp_q.push_back(e);
        e.sa = w[5:4];
        e.sb = w[3:2];
        e.op = (w[7] == 1'b0) ? {3'b000, w[6]} : 4'd0;
        exp_q.push_back(e);
        if (w[7:6] == 2'b11) break;
        if (w[7] == 1'b0) begin
          res = w[6] ? mrf[w[5:4]] - mrf[w[3:2]] : mrf[w[5:4]] + mrf[w[3:2]];
          mrf[w[1:0]] = res;
          e = idle_exp();
          e.busy = 1'b1;
          e.pc   = 3'(a);
          e.we   = 1'b1;
          e.wa   = w[1:0];
          e.wd   = res;
          exp_q.push_back(e);
        end
      end
    end
    e = idle_exp();
    e.done = 1'b1;
    exp_q.push_back(e);
  endtask

  // ---------------- monitor / compare ----------------
  initial begin : mon
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc_ctr++;
      if (wr_en) wr_log.push_back({wr_addr, wr_data});
      if (done) begin
        done_cnt++;
        last_done_rel = cyc_ctr - run_base;
      end
      if (chk_en) begin
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = idle_exp();
        chk($sformatf("cycle %0d", cyc_ctr),
            {8'd0, busy, done, pc, alu_sel_a, alu_sel_b, alu_op, wr_en,
             (e.we ? {wr_addr, wr_data} : 10'd0)},
            {8'd0, e.busy, e.done, e.pc, e.sa, e.sb, e.op, e.we,
             (e.we ? {e.wa, e.wd} : 10'd0)});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_rf(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d);
    @(negedge clk);
    rf_init[0] = a; rf_init[1] = b; rf_init[2] = c; rf_init[3] = d;
    mrf[0] = a; mrf[1] = b; mrf[2] = c; mrf[3] = d;
    rf_load = 1'b1;
    @(negedge clk);
    rf_load = 1'b0;
  endtask

  task automatic prog_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    mmem[a] = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL run_timeout: got %0d pending cycles expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Start a run; optionally write a word in the same cycle as start, and
  // optionally poke prog_we+start poke_cyc cycles into the run.
  task automatic run(input logic [3:0] lp, input bit sim_we, input logic [2:0] wa,
                     input logic [7:0] wd, input int poke_cyc,
                     output int log_base, output int done_base);
    @(negedge clk);
    start = 1'b1;
    loops = lp;
    if (sim_we) begin
      prog_we = 1'b1; prog_addr = wa; prog_data = wd;
      mmem[wa] = wd;
    end
    build_trace(int'(lp));
    run_base  = cyc_ctr;
    log_base  = wr_log.size();
    done_base = done_cnt;
    @(negedge clk);
    start   = 1'b0;
    prog_we = 1'b0;
    loops   = 4'($urandom);
    if (poke_cyc > 0) begin
      repeat (poke_cyc - 1) @(negedge clk);
      prog_we = 1'b1; prog_addr = 3'd0; prog_data = 8'h00; start = 1'b1;
      @(negedge clk);
      prog_we = 1'b0; start = 1'b0;
    end
    wait_empty();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int lb;
    int db;
    int sz;
    logic [7:0] w;
    rst = 1'b1; prog_we = 1'b0; prog_addr = 3'd0; prog_data = 8'd0;
    start = 1'b0; loops = 4'd0; rf_load = 1'b0;
    for (int i = 0; i < 8; i++) mmem[i] = 8'hFF;
    for (int i = 0; i < 4; i++) begin rf_init[i] = 8'd0; mrf[i] = 8'd0; end
    #1;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst wr_en", wr_en, 0);
    chk("rst pc", pc, 0);
    chk("rst sels", {alu_sel_a, alu_sel_b}, 4'b0001);
    chk("rst alu_op", alu_op, 0);
    chk("rst wr", {wr_addr, wr_data}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    // Single ADD then HALT.
    set_rf(8'd3, 8'd4, 8'd0, 8'd0);
    prog_write(3'd0, 8'h06);
    prog_write(3'd1, 8'hC0);
    run(4'd0, 1'b0, 3'd0, 8'd0, 0, lb, db);
    chk("add nwr", wr_log.size() - lb, 1);
    chk("add wr0", wr_log[lb], {2'd2, 8'd7});
    chk("add done_cyc", last_done_rel, 6);
    chk("add ndone", done_cnt - db, 1);

    // SUB repeated over three passes.
    set_rf(8'd1, 8'd0, 8'd0, 8'd10);
    prog_write(3'd0, 8'h73);
    prog_write(3'd1, 8'hC0);
    run(4'd2, 1'b0, 3'd0, 8'd0, 0, lb, db);
    chk("sub nwr", wr_log.size() - lb, 3);
    chk("sub wr0", wr_log[lb], {2'd3, 8'd9});
    chk("sub wr1", wr_log[lb+1], {2'd3, 8'd8});
    chk("sub wr2", wr_log[lb+2], {2'd3, 8'd7});
    chk("sub ndone", done_cnt - db, 1);

    // Full program without HALT wraps pc.
    set_rf(8'd3, 8'd4, 8'd0, 8'd0);
    for (int i = 0; i < 8; i++) prog_write(3'(i), 8'h06);
    run(4'd0, 1'b0, 3'd0, 8'd0, 0, lb, db);
    chk("full nwr", wr_log.size() - lb, 8);
    chk("full done_cyc", last_done_rel, 25);
    chk("full pc_after", pc, 0);

    // prog_we and start mid-run are ignored; then read the program back.
    run(4'd0, 1'b0, 3'd0, 8'd0, 3, lb, db);
    chk("poke ndone", done_cnt - db, 1);
    run(4'd0, 1'b0, 3'd0, 8'd0, 0, lb, db);
    chk("poke readback nwr", wr_log.size() - lb, 8);

    // NOP then HALT, NOP written in the same cycle as start.
    prog_write(3'd1, 8'hC0);
    run(4'd0, 1'b1, 3'd0, 8'h80, 0, lb, db);
    chk("nop nwr", wr_log.size() - lb, 0);
    chk("nop done_cyc", last_done_rel, 5);

    // Reset during EXEC of a write aborts the run.
    prog_write(3'd0, 8'h06);
    chk_en = 1'b0;
    @(negedge clk);
    start = 1'b1; loops = 4'd0;
    lb = wr_log.size();
    db = done_cnt;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort busy", busy, 0);
    chk("abort wr_en", wr_en, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) mmem[i] = 8'hFF;
    chk_en = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort nwr", wr_log.size() - lb, 0);
    chk("abort ndone", done_cnt - db, 0);
    run(4'd0, 1'b0, 3'd0, 8'd0, 0, lb, db);
    chk("post-rst nwr", wr_log.size() - lb, 0);
    chk("post-rst done_cyc", last_done_rel, 3);

    // Randomized programs, operands and pass counts.
    for (int it = 0; it < 12; it++) begin
      set_rf(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      for (int a = 0; a < 8; a++) begin
        sz = int'($urandom_range(0, 9));
        w  = 8'($urandom);
        if (sz == 0) w[7:6] = 2'b11;
        else if (sz == 1) w[7:6] = 2'b10;
        else w[7] = 1'b0;
        prog_write(3'(a), w);
      end
      run(4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          3'($urandom_range(0, 7)), 8'($urandom), 0, lb, db);
      chk($sformatf("rand%0d ndone", it), done_cnt - db, 1);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter PROG_DEPTH, 8, number of instruction words (fixed at 8; pc and prog_addr are 3 bits).
REQ-002 SHALL have ports: clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 prog_we  input  1  program-memory write strobe.
REQ-005 prog_addr  input  3  program-memory write address.
REQ-006 prog_data  input  8  instruction word to write.
REQ-007 start  input  1  begin program run, sampled on clk.
REQ-008 loops  input  4  extra passes; the run executes loops+1 passes.
REQ-009 busy  output  1  high while a run is in progress.
REQ-010 done  output  1  one-cycle pulse at run end.
REQ-011 pc  output  3  current instruction address.
REQ-012 alu_sel_a, alu_sel_b  output  2 each  ALU operand selects (00=A, 01=B, 10=C, 11=D).
REQ-013 alu_op  output  4  ALU opcode (0000 add, 0001 sub).
REQ-014 alu_result  input  8  combinational ALU result for the driven controls.
REQ-015 wr_en, wr_addr, wr_data  output  1/2/8  register-file write-back strobe, destination, data.

Function
REQ-016 Instruction format SHALL be [7:6] opcode (00 ADD, 01 SUB, 10 NOP, 11 HALT), [5:4] src_a, [3:2] src_b, [1:0] dst.
REQ-017 FSM SHALL have states IDLE, FETCH, EXEC, WB, DONE.
REQ-018 IDLE: start=1 -> latch loops into the pass counter, pc=0, go to FETCH; start=0 -> stay.
REQ-019 FETCH (1 cycle): load instr register from mem[pc]; go to EXEC.
REQ-020 EXEC (1 cycle): drive alu_sel_a=src_a, alu_sel_b=src_b, alu_op = {2'b00, opcode[0]} for ADD/SUB and 0000 otherwise.
REQ-021 EXEC ADD/SUB SHALL register alu_result into wr_data and dst into wr_addr, then go to WB.
REQ-022 EXEC NOP SHALL advance pc; EXEC HALT SHALL take the end-of-pass decision without a write.
REQ-023 WB (1 cycle): wr_en=1; pc advances; next state is FETCH unless end of pass.
REQ-024 End of pass SHALL occur on HALT in EXEC, or when advancing from pc=7 (no HALT needed).
REQ-025 At end of pass: if pass counter is non-zero, decrement it, set pc=0, and go to FETCH; else go to DONE.
REQ-026 pc SHALL wrap 7->0 at end of pass.
REQ-027 DONE (1 cycle): done=1; go to IDLE.
REQ-028 busy SHALL be 1 exactly in FETCH, EXEC and WB.
REQ-029 wr_en SHALL be 1 only in WB.
REQ-030 Outside EXEC, alu_sel_a=00, alu_sel_b=01 and alu_op=0000.
REQ-031 ADD/SUB SHALL take 3 cycles, NOP 2 cycles, and HALT 2 cycles plus 1 cycle of DONE.
REQ-032 prog_we SHALL write mem[prog_addr] only in IDLE or DONE; it is ignored while busy.
REQ-033 start while busy or in DONE SHALL be ignored.
REQ-034 Simultaneous prog_we and start in IDLE: the write SHALL complete, and the first FETCH sees the new word.

Reset
REQ-035 rst=1 SHALL immediately force IDLE and, without waiting for clk: busy=0, done=0, wr_en=0, pc=0, alu_sel_a=00, alu_sel_b=01, alu_op=0000, wr_addr=0, wr_data=0, pass counter=0, instr=8'hFF.
REQ-036 rst SHALL set all eight program words to 8'hFF (HALT).
REQ-037 rst asserted mid-run SHALL abort the run: no further wr_en and no done pulse.

Verification
REQ-038 Program {0x06, 0xC0}, loops=0, start at edge 0, ALU model A=3, B=4 -> busy in cycles 1-5, wr_en in cycle 3 with wr_addr=2 and wr_data=7, done in cycle 6, pc=0 after.
REQ-039 Program {0x73, 0xC0}, loops=2, ALU/regfile model D=10, A=1 -> three wr_en pulses writing 9, 8, 7 to wr_addr=3; one done pulse; busy is continuous until it.
REQ-040 All 8 words = 0x06, loops=0 -> 8 writes, pc sequence 0..7, done 25 cycles after start, pc wraps to 0.
REQ-041 prog_we to addr 0 (data 0x00) and start during a run -> memory is unchanged (readback by a later run), no restart, exactly one done.
REQ-042 NOP word (0x80) then HALT -> no wr_en; done 5 cycles after start.
REQ-043 rst pulse during EXEC of a write -> busy=0 and wr_en=0 before the next edge; a subsequent start with no reprogramming -> immediate HALT, done with no writes.
